// File: rtl/display_seg_scan_pkg.sv
// rtl/display_seg_scan_pkg.sv - glyph constants shared by the seven-segment scanner
package display_seg_scan_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit0=a .. bit6=g; element 0 is the rightmost (digit 0).
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_glyph(input nibble_t value);
    return SEG_GLYPHS[value];
  endfunction

endpackage

// File: rtl/display_seg_scan_seg7_hex_dec.sv
// rtl/display_seg_scan_seg7_hex_dec.sv - combinational nibble to active-low segment decoder
module seg7_hex_dec
  import display_seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_glyph(nibble);
  end

endmodule

// File: rtl/display_seg_scan.sv
// rtl/display_seg_scan.sv - multiplexed seven-segment scanner with
// double-buffered image, leading-zero suppression and blink
module display_seg_scan
  import display_seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_blink,
  input  logic                    cfg_lzs,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(PRESCALE);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic                    slot_end;
  logic                    frame_end;

  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blink;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blink;

  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [3:0]              sel_nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    lead_zero;
  logic                    blank;

  assign slot_end  = (pre == PRE_W'(PRESCALE - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign wr_ready  = ~pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      pre        <= slot_end ? '0 : pre + 1'b1;
      frame_tick <= frame_end;
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Transfer and capture are exclusive: a full buffer holds wr_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full  <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blink <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
    end else if (frame_end && pend_full) begin
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      act_blink <= pend_blink;
      pend_full <= 1'b0;
    end else if (wr_valid && wr_ready) begin
      pend_data  <= wr_data;
      pend_dp    <= wr_dp;
      pend_blink <= wr_blink;
      pend_full  <= 1'b1;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero = 1'b1;
    lz_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead_zero   = lead_zero && (act_data[4*i +: 4] == 4'h0);
      lz_blank[i] = lead_zero;
    end
  end

  assign sel_nibble = act_data[4*idx +: 4];
  assign blank      = (cfg_lzs && lz_blank[idx]) || (blink_phase && act_blink[idx]);

  seg7_hex_dec u_dec (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= blank ? SEG_BLANK : dec_seg;
      dp_n  <= blank || !act_dp[idx];
      an_n  <= ~(AN_ONE << idx);
    end
  end

endmodule

// File: tb/tb_display_seg_scan.sv
// tb/tb_display_seg_scan.sv - scoreboard bench for display_seg_scan (4 digits, prescale 4)
module tb_display_seg_scan;

  localparam int ND = 4;
  localparam int PS = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp = '0;
  logic [3:0]  wr_blink = '0;
  logic        cfg_lzs = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  display_seg_scan #(.NUM_DIGITS(ND), .PRESCALE(PS), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_blink   (wr_blink),
    .cfg_lzs    (cfg_lzs),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cur = 0;
  int pos = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // segs packed d3..d0, dpn packed d3..d0 (active-low)
  task automatic push_frame(input int f, input logic [27:0] segs, input logic [3:0] dpn);
    exp_t e;
    for (int s = 0; s < ND; s++) begin
      e.frame = f;
      e.slot  = s;
      e.an    = ~(4'b0001 << s);
      e.seg   = segs[7*s +: 7];
      e.dp    = dpn[s];
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    pos++;
    if (frame_tick) begin
      cur++;
      pos = 0;
    end
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      step();
      seen = frame_tick;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL wait_tick: no frame_tick within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && q.size() > 0; n++) step();
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                          output int appear);
    bit done = 0;
    appear   = -1;
    wr_data  = d;
    wr_dp    = dp;
    wr_blink = bl;
    wr_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (wr_ready) begin
        appear = (pos == 15) ? cur + 2 : cur + 1;
        done   = 1;
      end
      step();
    end
    wr_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL write_timeout: wr_ready never rose");
    end
  endtask

  // Monitor: one scoreboard pop per digit slot, plus frame_tick width/period and slot hold time.
  int         frame_no = 0;
  int         slot_no = -1;
  logic [3:0] prev_an = 4'hF;
  int         hold = 0;
  bit         hold_ok = 0;
  int         cyc = 0;
  int         last_tick = -1;
  logic       prev_tick = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      frame_no  = 0;
      slot_no   = -1;
      prev_an   = 4'hF;
      hold      = 0;
      hold_ok   = 0;
      cyc       = 0;
      last_tick = -1;
      prev_tick = 1'b0;
    end else begin
      cyc++;
      if (frame_tick) begin
        check("tick_width", {31'd0, prev_tick}, 32'd0);
        if (last_tick >= 0) check("tick_period", cyc - last_tick, ND * PS);
        last_tick = cyc;
        frame_no++;
        slot_no = -1;
      end
      prev_tick = frame_tick;
      if (an_n != prev_an) begin
        if (hold_ok) check("slot_hold", hold, PS);
        hold_ok = 1;
        hold    = 1;
        prev_an = an_n;
        slot_no++;
        while (q.size() > 0 && (q[0].frame < frame_no ||
               (q[0].frame == frame_no && q[0].slot < slot_no))) begin
          n_checks++;
          $display("FAIL missed_f%0d_s%0d: slot never observed (now f%0d s%0d)",
                   q[0].frame, q[0].slot, frame_no, slot_no);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].frame == frame_no && q[0].slot == slot_no) begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("f%0d_s%0d_an_seg_dp", frame_no, slot_no),
                {20'd0, an_n, seg_n, dp_n}, {20'd0, e.an, e.seg, e.dp});
        end
      end else begin
        hold++;
      end
    end
  end

  localparam logic [27:0] ZEROS = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] IMG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] IMG_5678 = {7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [27:0] IMG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};

  task automatic check_reset_outputs(input string tag);
    check({tag, "_seg_n"}, {25'd0, seg_n}, 32'h7F);
    check({tag, "_dp_n"}, {31'd0, dp_n}, 32'd1);
    check({tag, "_an_n"}, {28'd0, an_n}, 32'hF);
    check({tag, "_frame_tick"}, {31'd0, frame_tick}, 32'd0);
    check({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    int appear;

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    push_frame(0, ZEROS, 4'b1111);
    push_frame(1, ZEROS, 4'b1111);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("an_first_cycle", {28'd0, an_n}, 32'hF);
    cur = 0;
    pos = 0;

    // Image 1234 with dp on digit 2; second write held until the frame boundary.
    wait_tick();
    do_write(16'h1234, 4'b0100, 4'b0000, appear);
    check("w1234_appear", appear, 2);
    check("wr_ready_after_write", {31'd0, wr_ready}, 32'd0);
    push_frame(2, IMG_1234, 4'b1011);
    do_write(16'h5678, 4'b0000, 4'b0000, appear);
    check("w5678_appear", appear, 3);
    push_frame(3, IMG_5678, 4'b1111);

    // Leading-zero suppression on 0070, dp on digit 0 stays visible.
    wait_tick();
    cfg_lzs = 1'b1;
    do_write(16'h0070, 4'b0001, 4'b0000, appear);
    check("w0070_appear", appear, 4);
    push_frame(4, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1110);

    // Write accepted on the frame_end edge lands one frame later.
    wait_tick();
    repeat (15) step();
    do_write(16'hABCD, 4'b0000, 4'b0000, appear);
    check("wABCD_fe_appear", appear, 6);
    cfg_lzs = 1'b0;
    push_frame(5, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1110);
    push_frame(6, IMG_ABCD, 4'b1111);
    wait_drain();

    // Reset mid-frame with the pending buffer full.
    do_write(16'h9999, 4'b1111, 4'b0000, appear);
    check("pend_full_before_reset", {31'd0, wr_ready}, 32'd0);
    repeat (3) step();
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) step();
    push_frame(0, ZEROS, 4'b1111);
    push_frame(1, ZEROS, 4'b1111);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("wr_ready_after_release", {31'd0, wr_ready}, 32'd1);
    cur = 0;
    pos = 0;

    // Blink on digit 0 only: shown frames 0-1, blank 2-3, shown 4-5.
    wait_tick();
    do_write(16'h1234, 4'b0000, 4'b0001, appear);
    check("wblink_appear", appear, 2);
    push_frame(2, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'b1111);
    push_frame(3, {7'h79, 7'h24, 7'h30, 7'h7F}, 4'b1111);
    push_frame(4, IMG_1234, 4'b1111);
    push_frame(5, IMG_1234, 4'b1111);
    wait_drain();
    step();

    while (q.size() > 0) begin
      n_checks++;
      $display("FAIL leftover_f%0d_s%0d: expected slot never observed", q[0].frame, q[0].slot);
      void'(q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
